// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
// Contents:
//   tx_state_t    transmit FSM state encoding (IDLE, START, DATA, STOP)
//   START_BIT     line level of the start bit
//   STOP_BIT      line level of the stop bit and of the idle line
//   DATA_BITS     data bits per frame
//   clks_per_bit  rounded clock cycles per bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Round to nearest rather than truncate so the baud error stays within half a cycle.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and status bundle for the UART transmitter
// Signals:
//   tx_dv     byte offered this cycle (master -> slave)
//   tx_byte   byte to transmit, taken when tx_dv && tx_ready (master -> slave)
//   tx_ready  slave can take a byte this cycle (slave -> master)
//   tx_busy   frame on the line or bytes pending (slave -> master)
//   tx_done   one-cycle pulse on the last cycle of each stop bit (slave -> master)
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_dv;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_dv, tx_byte, input tx_ready, tx_busy, tx_done);
  modport slave  (input tx_dv, tx_byte, output tx_ready, tx_busy, tx_done);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with registered not-full flag
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push         write request, honoured only while not_full is high
//   push_data    data written on an honoured push
//   not_full     registered flag, low once DEPTH entries are stored and low in reset
//   pop          read request, honoured only while not empty
//   pop_data     entry at the head of the FIFO (valid while empty is low)
//   empty        no entries stored
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             not_full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  // A push while full is dropped even if a pop happens in the same cycle;
  // not_full then rises one cycle later from the decremented count.
  assign push_ok  = push && not_full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_d = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_d;
      not_full <= (count_d != (AW + 1)'(DEPTH));
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with holding register or optional FIFO
// Build option: define UART_TX_FIFO_EN to queue pending bytes in a FIFO_DEPTH-entry
// sync_fifo; otherwise a single holding register stores the next byte.
// Ports:
//   ICE_CLK  clock, all state changes on its rising edge
//   RST_N    asynchronous active-low reset
//   tx_if    uart_tx_if slave: tx_dv, tx_byte in; tx_ready, tx_busy, tx_done out
//   UART_TX  registered serial line output, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int UART_BAUD  = 921600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic     ICE_CLK,
  input  logic     RST_N,
  uart_tx_if.slave tx_if,
  output logic     UART_TX
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, UART_BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two of at least 2");
  end

  tx_state_t            state, state_d;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 pop;
  logic                 pending;
  logic [DATA_BITS-1:0] pend_byte;
  logic                 ready_q;

`ifdef UART_TX_FIFO_EN
  logic fifo_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (ICE_CLK),
    .rst_n     (RST_N),
    .push      (tx_if.tx_dv),
    .push_data (tx_if.tx_byte),
    .not_full  (ready_q),
    .pop       (pop),
    .pop_data  (pend_byte),
    .empty     (fifo_empty)
  );

  assign pending = !fifo_empty;
`else
  logic                 hold_valid, hold_valid_d;
  logic [DATA_BITS-1:0] hold_byte;
  logic                 push_ok;

  // ready_q only goes high while the register is empty and pop only fires while
  // it is full, so a push and a pop can never land in the same cycle.
  assign push_ok = tx_if.tx_dv && ready_q;

  always_comb begin
    hold_valid_d = hold_valid;
    if (pop)          hold_valid_d = 1'b0;
    else if (push_ok) hold_valid_d = 1'b1;
  end

  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_valid <= 1'b0;
      hold_byte  <= '0;
      ready_q    <= 1'b0;
    end else begin
      hold_valid <= hold_valid_d;
      ready_q    <= !hold_valid_d;
      if (push_ok) hold_byte <= tx_if.tx_byte;
    end
  end

  assign pending   = hold_valid;
  assign pend_byte = hold_byte;
`endif

  assign bit_end = (clk_cnt == CNT_LAST);

  // State register (also holds the datapath registers the FSM steers).
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      line_q  <= STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The pending byte is popped on the same edge that enters
  // START, which is what lets STOP run straight into the next START.
  always_comb begin
    state_d   = state;
    clk_cnt_d = '0;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    if (state != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (pending) begin
          state_d = START;
          pop     = 1'b1;
          shift_d = pend_byte;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift[DATA_BITS-1:1]};
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (pending) begin
            state_d = START;
            pop     = 1'b1;
            shift_d = pend_byte;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the next state so the registered line and done
  // flag line up with the state register rather than trailing it by a cycle.
  always_comb begin
    line_d = STOP_BIT;
    case (state_d)
      START:   line_d = START_BIT;
      DATA:    line_d = shift_d[0];
      default: line_d = STOP_BIT;
    endcase
    done_d = (state_d == STOP) && (clk_cnt_d == CNT_LAST);
  end

  assign UART_TX        = line_q;
  assign tx_if.tx_done  = done_q;
  assign tx_if.tx_ready = ready_q;
  assign tx_if.tx_busy  = (state != IDLE) || pending;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking scoreboard bench for uart_tx
module tb_uart_tx;

  localparam int CPB   = 13;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic ICE_CLK = 1'b0;
  logic RST_N   = 1'b1;
  logic UART_TX;
  int   passed  = 0;
  int   total   = 0;
  logic [7:0] exp_q[$];

  uart_tx_if tx_if ();

  uart_tx #(
    .CLK_FREQ   (12000000),
    .UART_BAUD  (921600),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .ICE_CLK (ICE_CLK),
    .RST_N   (RST_N),
    .tx_if   (tx_if),
    .UART_TX (UART_TX)
  );

  always #5 ICE_CLK = ~ICE_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog expired");
  end

  // Offer one byte for one clock; rdy is tx_ready as seen just before the edge.
  task automatic push_byte(input logic [7:0] b, output logic rdy);
    @(negedge ICE_CLK);
    tx_if.tx_dv   = 1'b1;
    tx_if.tx_byte = b;
    rdy           = tx_if.tx_ready;
    @(posedge ICE_CLK);
    #1 tx_if.tx_dv = 1'b0;
  endtask

  // Waits for a start bit, then samples the whole frame on falling edges.
  // gap = idle samples before the start bit (-1 on timeout).
  task automatic capture_frame(input int max_wait, output int gap, output logic [7:0] data,
                               output logic shape_ok, output logic done_ok, output logic stop_ok);
    logic [9:0] bits;
    int g;
    g = 0; bits = '0; data = '0;
    shape_ok = 1'b0; done_ok = 1'b0; stop_ok = 1'b0;
    @(negedge ICE_CLK);
    while (UART_TX !== 1'b0 && g < max_wait) begin
      @(negedge ICE_CLK);
      g++;
    end
    if (UART_TX !== 1'b0) begin
      gap = -1;
      return;
    end
    gap = g; shape_ok = 1'b1; done_ok = 1'b1;
    for (int s = 0; s < FRAME; s++) begin
      if (s > 0) @(negedge ICE_CLK);
      if (s % CPB == 0) bits[s / CPB] = UART_TX;
      else if (UART_TX !== bits[s / CPB]) shape_ok = 1'b0;
      if (tx_if.tx_done !== (s == FRAME - 1)) done_ok = 1'b0;
    end
    data    = bits[8:1];
    stop_ok = (bits[9] === 1'b1);
  endtask

  task automatic test_reset();
    logic idle_ok;
    tx_if.tx_dv = 1'b0; tx_if.tx_byte = 8'h00;
    #3 RST_N = 1'b0;
    repeat (3) @(negedge ICE_CLK);
    total++;
    if ({UART_TX, tx_if.tx_ready, tx_if.tx_busy, tx_if.tx_done} !== 4'b1000)
      $display("FAIL reset_outputs: got line/ready/busy/done=%b want 1000",
               {UART_TX, tx_if.tx_ready, tx_if.tx_busy, tx_if.tx_done});
    else passed++;
    // A byte offered across the release edge meets tx_ready=0 and must be dropped.
    tx_if.tx_dv = 1'b1; tx_if.tx_byte = 8'h5A;
    RST_N = 1'b1;
    #1;
    total++;
    if (tx_if.tx_ready !== 1'b0) $display("FAIL ready_at_release: got %b want 0", tx_if.tx_ready);
    else passed++;
    @(posedge ICE_CLK);
    #1 tx_if.tx_dv = 1'b0;
    total++;
    if (tx_if.tx_ready !== 1'b1) $display("FAIL ready_first_clock: got %b want 1", tx_if.tx_ready);
    else passed++;
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge ICE_CLK);
      if (UART_TX !== 1'b1 || tx_if.tx_busy !== 1'b0) idle_ok = 1'b0;
    end
    total++;
    if (idle_ok !== 1'b1) $display("FAIL ignored_byte_idle: got %b want 1", idle_ok);
    else passed++;
  endtask

  task automatic test_single();
    logic [7:0] pats[4];
    logic [7:0] d, e;
    logic rdy, sh, dn, st;
    int gap;
    pats = '{8'hA5, 8'h00, 8'hFF, 8'($urandom)};
    foreach (pats[i]) begin
      push_byte(pats[i], rdy);
      total++;
      if (rdy !== 1'b1) $display("FAIL single_ready[%0d]: got %b want 1", i, rdy);
      else begin passed++; exp_q.push_back(pats[i]); end
      capture_frame(20, gap, d, sh, dn, st);
      total++;
      if (gap < 0 || gap > 1) $display("FAIL single_latency[%0d]: got %0d want 0..1", i, gap);
      else passed++;
      total++;
      if (exp_q.size() == 0) $display("FAIL single_data[%0d]: got %h want <none>", i, d);
      else begin
        e = exp_q.pop_front();
        if (d !== e) $display("FAIL single_data[%0d]: got %h want %h", i, d, e);
        else passed++;
      end
      total++;
      if ({sh, dn, st} !== 3'b111) $display("FAIL single_shape[%0d]: got shape/done/stop=%b want 111", i, {sh, dn, st});
      else passed++;
      @(negedge ICE_CLK);
      total++;
      if ({tx_if.tx_busy, UART_TX} !== 2'b01) $display("FAIL single_busy_fall[%0d]: got busy/line=%b want 01", i, {tx_if.tx_busy, UART_TX});
      else passed++;
      repeat (3) @(negedge ICE_CLK);
    end
  endtask

  // Checks n captured frames against the scoreboard; first frame may wait a cycle, the rest none.
  task automatic test_frames_vs_queue(input string name, input int n, input int gaps[],
                                      input logic [7:0] datas[], input logic [2:0] shapes[]);
    logic [7:0] e;
    for (int f = 0; f < n; f++) begin
      total++;
      if ((f == 0 && (gaps[f] < 0 || gaps[f] > 1)) || (f > 0 && gaps[f] != 0))
        $display("FAIL %s_gap[%0d]: got %0d want %s", name, f, gaps[f], (f == 0) ? "0..1" : "0");
      else passed++;
      total++;
      if (exp_q.size() == 0) $display("FAIL %s_data[%0d]: got %h want <none>", name, f, datas[f]);
      else begin
        e = exp_q.pop_front();
        if (datas[f] !== e) $display("FAIL %s_data[%0d]: got %h want %h", name, f, datas[f], e);
        else passed++;
      end
      total++;
      if (shapes[f] !== 3'b111) $display("FAIL %s_shape[%0d]: got %b want 111", name, f, shapes[f]);
      else passed++;
    end
    @(negedge ICE_CLK);
    total++;
    if ({tx_if.tx_busy, UART_TX, exp_q.size() == 0} !== 3'b011)
      $display("FAIL %s_end: got busy/line/drained=%b want 011", name, {tx_if.tx_busy, UART_TX, exp_q.size() == 0});
    else passed++;
    repeat (3) @(negedge ICE_CLK);
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_holding();
    logic r0, r1, r2, sh, dn, st;
    int gaps[2];
    logic [7:0] datas[2];
    logic [2:0] shapes[2];
    push_byte(8'h3C, r0);
    exp_q.push_back(8'h3C);
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          capture_frame(200, gaps[f], datas[f], sh, dn, st);
          shapes[f] = {sh, dn, st};
        end
      end
      begin
        repeat (20) @(negedge ICE_CLK);
        push_byte(8'hC3, r1);
        exp_q.push_back(8'hC3);
        repeat (5) @(negedge ICE_CLK);
        push_byte(8'h99, r2);
      end
    join
    total++;
    if ({r0, r1, r2} !== 3'b110) $display("FAIL holding_ready: got %b want 110", {r0, r1, r2});
    else passed++;
    test_frames_vs_queue("holding", 2, gaps, datas, shapes);
  endtask
`else
  task automatic test_burst();
    logic r0, r1, r2, sh, dn, st;
    int gaps[3];
    logic [7:0] datas[3];
    logic [2:0] shapes[3];
    push_byte(8'h00, r0);
    exp_q.push_back(8'h00);
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          capture_frame(200, gaps[f], datas[f], sh, dn, st);
          shapes[f] = {sh, dn, st};
        end
      end
      begin
        push_byte(8'hFF, r1); exp_q.push_back(8'hFF);
        push_byte(8'h55, r2); exp_q.push_back(8'h55);
      end
    join
    total++;
    if ({r0, r1, r2} !== 3'b111) $display("FAIL burst_ready: got %b want 111", {r0, r1, r2});
    else passed++;
    test_frames_vs_queue("burst", 3, gaps, datas, shapes);
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[20];
    logic exp_acc[20];
    logic got[20];
    logic sh, dn, st;
    int c, n_acc;
    int gaps[17];
    logic [7:0] datas[17];
    logic [2:0] shapes[17];
    foreach (bytes[i]) bytes[i] = 8'($urandom);
    push_byte(bytes[0], got[0]);
    exp_acc[0] = 1'b1; exp_q.push_back(bytes[0]);
    c = 1; n_acc = 1;
    // Pending-count model: ready reflects the count after the previous edge;
    // the first byte leaves the store on the edge that takes byte 1.
    for (int i = 1; i < 20; i++) begin
      exp_acc[i] = (c < DEPTH);
      if (exp_acc[i]) begin c++; n_acc++; exp_q.push_back(bytes[i]); end
      if (i == 1) c--;
    end
    fork
      begin
        for (int f = 0; f < 17; f++) begin
          capture_frame(200, gaps[f], datas[f], sh, dn, st);
          shapes[f] = {sh, dn, st};
        end
      end
      begin
        for (int i = 1; i < 20; i++) push_byte(bytes[i], got[i]);
      end
    join
    for (int i = 0; i < 20; i++) begin
      total++;
      if (got[i] !== exp_acc[i]) $display("FAIL overflow_ready[%0d]: got %b want %b", i, got[i], exp_acc[i]);
      else passed++;
    end
    total++;
    if (n_acc != 17) $display("FAIL overflow_model_count: got %0d want 17", n_acc);
    else passed++;
    test_frames_vs_queue("overflow", 17, gaps, datas, shapes);
  endtask
`endif

  task automatic test_reset_mid();
    logic rdy, idle_ok, sh, dn, st;
    logic [7:0] d, e;
    int gap;
    push_byte(8'h81, rdy);
    exp_q.push_back(8'h81);
    repeat (62) @(negedge ICE_CLK);
    total++;
    if (UART_TX !== 1'b0) $display("FAIL midframe_line: got %b want 0", UART_TX);
    else passed++;
    #1 RST_N = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if ({UART_TX, tx_if.tx_ready, tx_if.tx_busy, tx_if.tx_done} !== 4'b1000)
      $display("FAIL async_reset: got line/ready/busy/done=%b want 1000",
               {UART_TX, tx_if.tx_ready, tx_if.tx_busy, tx_if.tx_done});
    else passed++;
    @(negedge ICE_CLK);
    RST_N = 1'b1;
    idle_ok = 1'b1;
    repeat (200) begin
      @(negedge ICE_CLK);
      if (UART_TX !== 1'b1 || tx_if.tx_busy !== 1'b0) idle_ok = 1'b0;
    end
    total++;
    if (idle_ok !== 1'b1) $display("FAIL no_resume: got %b want 1", idle_ok);
    else passed++;
    push_byte(8'h42, rdy);
    exp_q.push_back(8'h42);
    capture_frame(20, gap, d, sh, dn, st);
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (rdy !== 1'b1 || gap < 0 || gap > 1 || d !== e || {sh, dn, st} !== 3'b111)
      $display("FAIL after_reset_frame: got rdy=%b gap=%0d data=%h shape=%b want rdy=1 gap<=1 data=%h shape=111",
               rdy, gap, d, {sh, dn, st}, e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef UART_TX_FIFO_EN
    test_holding();
`else
    test_burst();
    test_overflow();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
